// File: rtl/perf_monitor_sequencer.sv
// perf_monitor_sequencer: runs clear/start/wait/forward measurement campaigns over every
// monitored stream and forwards each counter value on an AXI-Stream result port.
module perf_monitor_sequencer #(
    parameter int          INPUT_STREAMS  = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h20_0000
) (
    input  logic        aclk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] rounds,
    output logic [31:0] pm_command,
    input  logic        pm_ready_to_read,
    input  logic [31:0] pm_counter_value,
    output logic        res_tvalid,
    input  logic        res_tready,
    output logic [31:0] res_tdata,
    output logic [7:0]  res_tuser,
    output logic        res_tlast,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, CLEAR, ARM, WAIT, OUT, FIN} state_t;
    localparam logic [7:0] LAST_IDX = 8'(INPUT_STREAMS - 1);
    state_t      state;
    logic [7:0]  idx;
    logic [15:0] round, last_round;
    logic [31:0] wait_cnt;
    logic        seen_low, accept, last_idx, final_res;
    // a ready level only counts once it has been seen low inside this WAIT
    assign accept    = seen_low && pm_ready_to_read;
    assign last_idx  = idx == LAST_IDX;
    assign final_res = last_idx && round == last_round;
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pm_command  <= '0;
            res_tvalid  <= 1'b0;
            res_tdata   <= '0;
            res_tuser   <= '0;
            res_tlast   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            idx         <= '0;
            round       <= '0;
            last_round  <= '0;
            wait_cnt    <= '0;
            seen_low    <= 1'b0;
        end else if (abort && state != IDLE && state != FIN) begin
            state      <= IDLE;
            pm_command <= '0;
            res_tvalid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        round       <= '0;
                        last_round  <= (rounds == 16'd0) ? 16'd0 : rounds - 16'd1;
                        pm_command  <= {2'b01, 22'b0, 8'd0};
                    end
                end
                CLEAR: begin
                    state      <= ARM;
                    pm_command <= {2'b10, 22'b0, idx};
                end
                ARM: begin
                    state      <= WAIT;
                    pm_command <= {24'b0, idx};
                    wait_cnt   <= '0;
                    seen_low   <= 1'b0;
                end
                WAIT: begin
                    seen_low <= seen_low | ~pm_ready_to_read;
                    wait_cnt <= wait_cnt + 32'd1;
                    if (accept || wait_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        state       <= OUT;
                        res_tvalid  <= 1'b1;
                        res_tdata   <= accept ? pm_counter_value : 32'hFFFF_FFFF;
                        res_tuser   <= idx;
                        res_tlast   <= final_res;
                        timeout_err <= timeout_err | ~accept;
                    end
                end
                OUT: begin
                    if (res_tready) begin
                        res_tvalid <= 1'b0;
                        res_tlast  <= 1'b0;
                        state      <= final_res ? FIN : CLEAR;
                        done       <= final_res;
                        idx        <= last_idx ? 8'd0 : idx + 8'd1;
                        round      <= (last_idx && !final_res) ? round + 16'd1 : round;
                        pm_command <= final_res ? 32'd0 : {2'b01, 22'b0, last_idx ? 8'd0 : idx + 8'd1};
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perf_monitor_sequencer.sv
// tb_perf_monitor_sequencer: directed and random campaigns checked every cycle against
// a procedural campaign model (loops over rounds/streams) plus literal pins.
module tb_perf_monitor_sequencer;
    localparam int NS = 4;
    localparam int TO = 100;
    logic        aclk = 0, resetn = 1, start = 0, abort = 0, pm_ready_to_read = 0, res_tready = 1;
    logic [15:0] rounds = 0;
    logic [31:0] pm_counter_value = 0;
    logic [31:0] pm_command, res_tdata;
    logic [7:0]  res_tuser;
    logic        res_tvalid, res_tlast, busy, done, timeout_err;

    perf_monitor_sequencer #(.INPUT_STREAMS(NS), .TIMEOUT_CYCLES(32'(TO))) dut (
        .aclk(aclk), .resetn(resetn), .start(start), .abort(abort), .rounds(rounds),
        .pm_command(pm_command), .pm_ready_to_read(pm_ready_to_read),
        .pm_counter_value(pm_counter_value), .res_tvalid(res_tvalid), .res_tready(res_tready),
        .res_tdata(res_tdata), .res_tuser(res_tuser), .res_tlast(res_tlast),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor stand-in: ready rises dly cycles after START, drops on CLEAR; modes force it
    int mode = 0, dly = 50, mon_cnt = -1;
    initial forever begin
        @(negedge aclk);
        #2;
        pm_counter_value = $urandom;
        if (pm_command[30]) begin
            pm_ready_to_read = 0;
            mon_cnt = -1;
        end else if (pm_command[31]) mon_cnt = dly;
        else if (mon_cnt > 0) begin
            mon_cnt--;
            if (mon_cnt == 0) pm_ready_to_read = 1;
        end
        if (mode == 1) pm_ready_to_read = 1;
        else if (mode == 2) pm_ready_to_read = 1'($urandom);
        else if (mode == 3) pm_ready_to_read = 0;
    end

    // model: expected outputs after each rising edge
    bit          e_busy, e_done, e_tvalid, e_tlast, e_terr, m_terr;
    logic [31:0] e_cmd, e_tdata;
    logic [7:0]  e_tuser;

    task automatic set_idle(input bit d);
        e_busy = 0; e_done = d; e_tvalid = 0; e_cmd = 0; e_terr = m_terr;
    endtask

    task automatic mstep(output bit kill);
        @(posedge aclk);
        kill = !resetn || abort;
        if (!resetn) begin
            m_terr = 0;
            set_idle(0);
        end else if (abort) set_idle(1);
    endtask

    task automatic run_campaign();
        int nr;
        bit kill, got, seen;
        logic [31:0] data;
        nr = (rounds == 0) ? 1 : int'(rounds);
        m_terr = 0;
        e_terr = 0;
        for (int r = 0; r < nr; r++)
            for (int i = 0; i < NS; i++) begin
                e_busy = 1; e_done = 0; e_tvalid = 0;
                e_cmd = 32'h4000_0000 | i;
                mstep(kill); if (kill) return;
                e_cmd = 32'h8000_0000 | i;
                mstep(kill); if (kill) return;
                e_cmd = i;
                got = 0; seen = 0; data = 32'hFFFF_FFFF;
                for (int w = 0; w < TO && !got; w++) begin
                    mstep(kill); if (kill) return;
                    if (seen && pm_ready_to_read) begin
                        got = 1;
                        data = pm_counter_value;
                    end
                    seen |= !pm_ready_to_read;
                end
                if (!got) m_terr = 1;
                e_tvalid = 1; e_tdata = data; e_tuser = 8'(i);
                e_tlast = (r == nr - 1) && (i == NS - 1); e_terr = m_terr;
                do begin
                    mstep(kill); if (kill) return;
                end while (!res_tready);
            end
        e_done = 1; e_tvalid = 0; e_cmd = 0;
        @(posedge aclk);
        if (!resetn) m_terr = 0;
        set_idle(0);
    endtask

    initial begin
        set_idle(0);
        forever begin
            @(posedge aclk);
            if (!resetn) begin
                m_terr = 0;
                set_idle(0);
            end else if (start) run_campaign();
            else e_done = 0;
        end
    end

    bit chk_on = 0;
    initial forever begin
        @(negedge aclk);
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("tvalid", 32'(res_tvalid), 32'(e_tvalid));
            chk("pm_command", pm_command, e_cmd);
            chk("timeout_err", 32'(timeout_err), 32'(e_terr));
            if (e_tvalid) begin
                chk("tdata", res_tdata, e_tdata);
                chk("tuser", 32'(res_tuser), 32'(e_tuser));
                chk("tlast", 32'(res_tlast), 32'(e_tlast));
            end
        end
    end

    int n_hs = 0, n_last = 0, n_done = 0;
    always @(posedge aclk) if (resetn && res_tvalid && res_tready) begin
        n_hs++;
        if (res_tlast) n_last++;
    end
    always @(negedge aclk) if (done) n_done++;

    task automatic pulse_start(input logic [15:0] r);
        @(negedge aclk);
        start = 1;
        rounds = r;
        @(negedge aclk);
        start = 0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (busy && k < lim) begin
            @(negedge aclk);
            k++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input int lim);
        int k = 0;
        while (!res_tvalid && k < lim) begin
            @(negedge aclk);
            k++;
        end
        chk("valid_wait", 32'(res_tvalid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1);
    end

    int n0, l0, d0;
    initial begin
        #3 resetn = 0;
        chk_on = 1;
        repeat (2) @(negedge aclk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd", pm_command, 0);
        chk("rst_tvalid", 32'(res_tvalid), 0);
        chk("rst_tdata", res_tdata, 0);
        chk("rst_terr", 32'(timeout_err), 0);
        #2 resetn = 1;

        // basic campaign: command sequence, result count, single done
        mode = 0; dly = 50; res_tready = 1;
        n0 = n_hs; l0 = n_last; d0 = n_done;
        pulse_start(1);
        chk("cmd_clear", pm_command, 32'h4000_0000);
        @(negedge aclk);
        chk("cmd_start", pm_command, 32'h8000_0000);
        @(negedge aclk);
        chk("cmd_wait", pm_command, 32'h0000_0000);
        wait_idle(2000);
        chk("a_results", 32'(n_hs - n0), 4);
        chk("a_tlast", 32'(n_last - l0), 1);
        chk("a_done", 32'(n_done - d0), 1);

        // back-pressure: result held with no new command
        dly = 10; res_tready = 0;
        pulse_start(1);
        wait_valid(300);
        repeat (20) @(negedge aclk);
        chk("bp_tvalid", 32'(res_tvalid), 1);
        chk("bp_tuser", 32'(res_tuser), 0);
        chk("bp_cmd", pm_command, 32'h0000_0000);
        chk("bp_tlast", 32'(res_tlast), 0);
        res_tready = 1;
        wait_idle(2000);

        // stale ready: no capture until it is seen low, then timeouts on the rest
        mode = 1;
        pulse_start(1);
        repeat (12) @(negedge aclk);
        chk("stale_nocap", 32'(res_tvalid), 0);
        mode = 3;
        @(negedge aclk);
        mode = 1;
        wait_valid(20);
        chk("stale_tuser", 32'(res_tuser), 0);
        chk("stale_terr", 32'(timeout_err), 0);
        wait_idle(1000);
        chk("stuck_terr", 32'(timeout_err), 1);
        pulse_start(1);
        wait_valid(200);
        chk("stuck_tdata", res_tdata, 32'hFFFF_FFFF);
        wait_idle(1000);

        // ready and timeout on the same edge: ready wins
        mode = 0; dly = TO;
        pulse_start(1);
        chk("terr_cleared", 32'(timeout_err), 0);
        wait_idle(1000);
        chk("tie_terr", 32'(timeout_err), 0);
        dly = TO + 1;
        pulse_start(1);
        wait_idle(1000);
        chk("late_terr", 32'(timeout_err), 1);

        // rounds 0 and 3
        dly = 4;
        n0 = n_hs;
        pulse_start(0);
        wait_idle(1000);
        chk("r0_results", 32'(n_hs - n0), 4);
        n0 = n_hs; l0 = n_last;
        pulse_start(3);
        wait_idle(2000);
        chk("r3_results", 32'(n_hs - n0), 12);
        chk("r3_tlast", 32'(n_last - l0), 1);

        // abort in WAIT and OUT, async reset in WAIT
        dly = 50;
        pulse_start(1);
        repeat (3) @(negedge aclk);
        abort = 1;
        @(negedge aclk);
        abort = 0;
        chk("abw_busy", 32'(busy), 0);
        chk("abw_done", 32'(done), 1);
        chk("abw_cmd", pm_command, 0);
        dly = 5; res_tready = 0;
        pulse_start(1);
        wait_valid(300);
        abort = 1;
        @(negedge aclk);
        abort = 0;
        chk("abo_tvalid", 32'(res_tvalid), 0);
        chk("abo_done", 32'(done), 1);
        res_tready = 1;
        pulse_start(1);
        repeat (3) @(negedge aclk);
        d0 = n_done;
        #2 resetn = 0;
        #1;
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_cmd", pm_command, 0);
        @(negedge aclk);
        #2 resetn = 1;
        chk("rstw_nodone", 32'(n_done - d0), 0);
        n0 = n_hs;
        pulse_start(1);
        wait_idle(1000);
        chk("clean_results", 32'(n_hs - n0), 4);

        // random traffic, stray starts and aborts
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            if (c % 500 == 0) mode = $urandom_range(0, 2);
            dly = $urandom_range(1, 12);
            res_tready = ($urandom % 4) != 0;
            start = ($urandom % 40) == 0;
            rounds = 16'($urandom_range(0, 2));
            abort = ($urandom % 300) == 0;
        end
        @(negedge aclk);
        start = 0; abort = 0; res_tready = 1;
        wait_idle(3000);
        repeat (3) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
